// File: rtl/hba_sonar_sched_pkg.sv
// hba_sonar_sched_pkg
//   Shared definitions for the HBA sonar ping scheduler: FSM state encodings
//   and a width helper. The register peripheral and the bench import the
//   same package, so the state encodings are defined in one place.
//   The timeout result is the all-ones value of the result width ('1).
// Ports: none (package).
package hba_sonar_sched_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_TRIG      = 3'd1;
   localparam logic [2:0] ST_WAIT_RISE = 3'd2;
   localparam logic [2:0] ST_MEASURE   = 3'd3;
   localparam logic [2:0] ST_HOLDOFF   = 3'd4;

   // clog2 with a floor of 1 bit, so one- and two-entry ranges still get a real signal.
   function automatic int min1_clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hba_sonar_sched_if.sv
// hba_sonar_sched_if
//   Bundles the scheduler's peripheral-side and pin-side signals.
//   master : the scheduler (drives triggers, results, busy)
//   slave  : the register peripheral / pin side (drives mask and echoes)
// Signals:
//   en_mask      channel enables
//   sonar_trig   trigger outputs, at most one high
//   sonar_echo   asynchronous echo inputs
//   dist_value   last echo width in us (all-ones on timeout)
//   dist_chan    channel of dist_value
//   dist_timeout last result was a timeout
//   dist_valid   one-clock strobe, dist_* updated this cycle
//   busy         scheduler not idle
interface hba_sonar_sched_if #(
   parameter int NUM_SONAR = 2,
   parameter int DWIDTH    = 16
);
   import hba_sonar_sched_pkg::*;

   localparam int CHAN_W = min1_clog2(NUM_SONAR);

   logic [NUM_SONAR-1:0] en_mask;
   logic [NUM_SONAR-1:0] sonar_trig;
   logic [NUM_SONAR-1:0] sonar_echo;
   logic [DWIDTH-1:0]    dist_value;
   logic [CHAN_W-1:0]    dist_chan;
   logic                 dist_timeout;
   logic                 dist_valid;
   logic                 busy;

   modport master (
      input  en_mask, sonar_echo,
      output sonar_trig, dist_value, dist_chan, dist_timeout, dist_valid, busy
   );

   modport slave (
      output en_mask, sonar_echo,
      input  sonar_trig, dist_value, dist_chan, dist_timeout, dist_valid, busy
   );

endinterface

// File: rtl/hba_us_tick.sv
// hba_us_tick
//   Microsecond prescaler: counts 0..US_DIV-1 and flags the terminal count.
//   A synchronous restart forces the count back to 0, so a state entered
//   with restart sees its first tick exactly US_DIV clocks later.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high
//   restart in  synchronous restart to count 0
//   tick    out high on the terminal count
module hba_us_tick
   import hba_sonar_sched_pkg::*;
#(
   parameter int US_DIV = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = min1_clog2(US_DIV);
   localparam logic [CW-1:0] TERM = CW'(US_DIV - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (reset || restart)
         cnt_reg <= '0;
      else if (cnt_reg == TERM)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign tick = (cnt_reg == TERM);

endmodule

// File: rtl/hba_sonar_sched.sv
// hba_sonar_sched
//   Time-multiplexed ping scheduler: fires one sonar channel at a time
//   (trigger pulse, echo width in us, holdoff) and moves round-robin to the
//   next enabled channel so sensors never hear each other's pings.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   bus    hba_sonar_sched_if.master: en_mask/sonar_echo in;
//          sonar_trig, dist_value, dist_chan, dist_timeout, dist_valid, busy out
module hba_sonar_sched
   import hba_sonar_sched_pkg::*;
#(
   parameter int CLK_FREQUENCY   = 50_250_000,
   parameter int NUM_SONAR       = 2,
   parameter int TRIG_US         = 10,
   parameter int ECHO_TIMEOUT_US = 30000,
   parameter int HOLDOFF_US      = 10000,
   parameter int DWIDTH          = 16
) (
   input  logic                clk,
   input  logic                reset,
   hba_sonar_sched_if.master   bus
);

   localparam int          US_DIV     = CLK_FREQUENCY / 1_000_000;
   localparam int          CHAN_W     = min1_clog2(NUM_SONAR);
   localparam logic [31:0] TRIG_LAST  = 32'(TRIG_US - 1);
   localparam logic [31:0] ECHO_LAST  = 32'(ECHO_TIMEOUT_US - 1);
   localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_US - 1);
   localparam logic [31:0] RESULT_MAX = 32'((64'd1 << DWIDTH) - 64'd1);

   logic [2:0]           state_reg, state_next;
   logic [CHAN_W-1:0]    chan_reg, chan_next;
   logic [CHAN_W-1:0]    rr_reg, rr_next;
   // One counter serves every state's duration; the published width is
   // clamped to the result range, which gives a saturating measurement.
   logic [31:0]          us_cnt_reg;
   logic [NUM_SONAR-1:0] echo_meta_reg, echo_sync_reg;
   logic                 echo_prev_reg;
   logic [NUM_SONAR-1:0] trig_reg, trig_next;
   logic [DWIDTH-1:0]    dist_value_reg;
   logic [CHAN_W-1:0]    dist_chan_reg;
   logic                 dist_timeout_reg, dist_valid_reg;

   logic tick, restart, echo_sel, echo_rise, echo_fall, pub, pub_timeout;

   // First enabled channel strictly after ptr, wrapping; ptr itself comes last.
   function automatic logic [CHAN_W-1:0] pick_next(input logic [NUM_SONAR-1:0] mask,
                                                   input logic [CHAN_W-1:0]    ptr);
      logic [CHAN_W-1:0] sel;
      logic              found;
      int                idx;
      sel   = ptr;
      found = 1'b0;
      for (int k = 1; k <= NUM_SONAR; k++) begin
         idx = (int'(ptr) + k) % NUM_SONAR;
         if (!found && mask[CHAN_W'(idx)]) begin
            sel   = CHAN_W'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   hba_us_tick #(.US_DIV(US_DIV)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   // Edge detection runs on the selected channel only. echo_prev_reg follows
   // the selected bit through TRIG, so an echo already high when WAIT_RISE
   // starts is not mistaken for a rise.
   assign echo_sel  = echo_sync_reg[chan_reg];
   assign echo_rise = echo_sel && !echo_prev_reg;
   assign echo_fall = !echo_sel && echo_prev_reg;

   always_comb begin
      state_next  = state_reg;
      chan_next   = chan_reg;
      rr_next     = rr_reg;
      pub         = 1'b0;
      pub_timeout = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (|bus.en_mask) begin
               chan_next  = pick_next(bus.en_mask, rr_reg);
               state_next = ST_TRIG;
            end
         end
         ST_TRIG: begin
            if (tick && us_cnt_reg == TRIG_LAST)
               state_next = ST_WAIT_RISE;
         end
         ST_WAIT_RISE: begin
            if (echo_rise) begin
               state_next = ST_MEASURE;
            end else if (tick && us_cnt_reg == ECHO_LAST) begin
               pub         = 1'b1;
               pub_timeout = 1'b1;
               state_next  = ST_HOLDOFF;
            end
         end
         ST_MEASURE: begin
            // A fall wins over a coinciding tick: that last tick is not counted.
            if (echo_fall) begin
               pub        = 1'b1;
               state_next = ST_HOLDOFF;
            end else if (tick && us_cnt_reg == ECHO_LAST) begin
               pub         = 1'b1;
               pub_timeout = 1'b1;
               state_next  = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (tick && us_cnt_reg == HOLD_LAST) begin
               rr_next    = chan_reg;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Every state change restarts the prescaler and the us counter.
   assign restart = (state_next != state_reg);

   for (genvar gi = 0; gi < NUM_SONAR; gi++) begin : g_trig
      assign trig_next[gi] = (state_next == ST_TRIG) && (chan_next == CHAN_W'(gi));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         chan_reg         <= '0;
         rr_reg           <= CHAN_W'(NUM_SONAR - 1);
         us_cnt_reg       <= '0;
         echo_meta_reg    <= '0;
         echo_sync_reg    <= '0;
         echo_prev_reg    <= 1'b0;
         trig_reg         <= '0;
         dist_value_reg   <= '0;
         dist_chan_reg    <= '0;
         dist_timeout_reg <= 1'b0;
         dist_valid_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         chan_reg      <= chan_next;
         rr_reg        <= rr_next;
         echo_meta_reg <= bus.sonar_echo;
         echo_sync_reg <= echo_meta_reg;
         echo_prev_reg <= echo_sel;
         trig_reg      <= trig_next;
         if (restart)
            us_cnt_reg <= '0;
         else if (tick)
            us_cnt_reg <= us_cnt_reg + 32'd1;
         dist_valid_reg <= pub;
         if (pub) begin
            dist_value_reg   <= (pub_timeout || us_cnt_reg > RESULT_MAX) ? '1
                                                                         : us_cnt_reg[DWIDTH-1:0];
            dist_chan_reg    <= chan_reg;
            dist_timeout_reg <= pub_timeout;
         end
      end
   end

   assign bus.sonar_trig   = trig_reg;
   assign bus.dist_value   = dist_value_reg;
   assign bus.dist_chan    = dist_chan_reg;
   assign bus.dist_timeout = dist_timeout_reg;
   assign bus.dist_valid   = dist_valid_reg;
   assign bus.busy         = (state_reg != ST_IDLE);

endmodule
